// File: rtl/fp_mul_scheduler.sv
// Round-robin share of one combinational FP32 multiplier between two requesters.
// Optional FP_MUL_STICKY_FLAGS_EN adds accumulated flags (sticky_flags, sticky_clr).
module fp_mul_scheduler #(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid0,
    output logic        req_ready0,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    output logic        rsp_valid0,
    input  logic        rsp_ack0,
    input  logic        req_valid1,
    output logic        req_ready1,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    output logic        rsp_valid1,
    input  logic        rsp_ack1,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_flags,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_result,
    input  logic [3:0]  mul_flags,
    output logic        busy
`ifdef FP_MUL_STICKY_FLAGS_EN
    ,
    output logic [3:0]  sticky_flags,
    input  logic        sticky_clr
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  flags_q, flags_d;
    logic [1:0]  vld_q, vld_d;
    logic        idle;
    logic        gnt1;
    logic        capture;

    // Port 1 wins when alone, or on a tie when port 0 had the last grant.
    assign idle       = (state_q == IDLE);
    assign gnt1       = req_valid1 & (~req_valid0 | ~last_q);
    assign req_ready0 = idle & req_valid0 & ~gnt1;
    assign req_ready1 = idle & gnt1;
    assign capture    = (state_q == EXEC) && (cnt_q == '0);

    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign rsp_data   = data_q;
    assign rsp_flags  = flags_q;
    assign rsp_valid0 = vld_q[0];
    assign rsp_valid1 = vld_q[1];
    assign busy       = ~idle;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        flags_d = flags_q;
        vld_d   = vld_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid0 | req_valid1) begin
                    a_d     = gnt1 ? req_a1 : req_a0;
                    b_d     = gnt1 ? req_b1 : req_b0;
                    owner_d = gnt1;
                    last_d  = gnt1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    data_d  = mul_result;
                    flags_d = mul_flags;
                    vld_d   = owner_q ? 2'b10 : 2'b01;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (owner_q ? rsp_ack1 : rsp_ack0) begin
                    vld_d   = 2'b00;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            flags_q <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            flags_q <= flags_d;
            vld_q   <= vld_d;
        end
    end

`ifdef FP_MUL_STICKY_FLAGS_EN
    logic [3:0] sticky_q, sticky_d;

    // A clear coinciding with a capture leaves only the new flags.
    always_comb begin
        sticky_d = sticky_clr ? 4'b0000 : sticky_q;
        if (capture) begin
            sticky_d = sticky_d | mul_flags;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_flags = sticky_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule
